fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the decode stage.
- Holds the PC and issues 64-bit instruction reads to instruction memory over a request/grant + in-order response interface.
- Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake.
- Handles branch redirects by flushing the buffer and discarding stale in-flight responses.

---
 rtl/fetch_unit_if.sv | 45 ++++
 rtl/fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_fetch_unit.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port and decode handshake.
// master = fetch unit, slave = memory/decode side.
interface fetch_unit_if #(
  parameter int ADDR_W = 64
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [0:63]       imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [0:63]       instr;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    input  redirect,
    input  redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    output redirect,
    output redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-gated memory reads, instruction
// buffer with registered head, redirect flush with stale-response drop.
module fetch_unit #(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         n_rst,
  fetch_unit_if.master bus
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH = (CW+1)'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_START,
    S_RUN,
    S_FLUSH
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rpc_q, rpc_d;
  logic [CW-1:0]     out_q, out_d;
  logic [CW-1:0]     disc_q, disc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic              val_q, val_d;
  logic [0:63]       ins_q, ins_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;

  logic [ADDR_W-1:0] pcs_q [BUF_DEPTH];
  logic [0:63]       wrd_q [BUF_DEPTH];

  logic              req;
  logic              gnt;
  logic              rsp;
  logic              drop;
  logic              push;
  logic              pop;
  logic [CW:0]       occ;
  logic [CW-1:0]     left;
  logic [ADDR_W-1:0] tgt;

  assign tgt  = bus.redirect_pc & ~ADDR_W'(7);
  assign pop  = val_q & bus.instr_ready;
  assign rsp  = bus.imem_rvalid;
  // credit counts the head leaving this cycle as free
  assign occ  = {1'b0, out_q} + {1'b0, cnt_q}
              - (CW+1)'(pop);
  assign req  = (state_q == S_RUN)
              & ~bus.redirect
              & (occ < DEPTH);
  assign gnt  = req & bus.imem_gnt;
  assign drop = rsp & (disc_q != '0);
  assign push = rsp & ~drop & ~bus.redirect;
  assign left = cnt_q - CW'(pop);

  always_comb begin
    out_d   = out_q + CW'(gnt) - CW'(rsp);
    pc_d    = pc_q;
    rpc_d   = rpc_q;
    disc_d  = disc_q;
    state_d = state_q;
    if (gnt)  pc_d   = pc_q + ADDR_W'(8);
    if (push) rpc_d  = rpc_q + ADDR_W'(8);
    if (drop) disc_d = disc_q - CW'(1);
    if (bus.redirect) begin
      pc_d   = tgt;
      rpc_d  = tgt;
      disc_d = out_d;
    end
    unique case (state_q)
      S_START: state_d = bus.redirect ? S_START : S_RUN;
      default: state_d = (disc_d != '0) ? S_FLUSH : S_RUN;
    endcase
  end

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (bus.redirect) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  // next head: bypass the incoming word when the buffer drains to it
  always_comb begin
    val_d = ~bus.redirect & (cnt_d != '0);
    ins_d = ins_q;
    ipc_d = ipc_q;
    if (val_d) begin
      if (push && left == '0) begin
        ins_d = bus.imem_rdata;
        ipc_d = rpc_q;
      end else begin
        ins_d = wrd_q[rd_d];
        ipc_d = pcs_q[rd_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wrd_q[wr_q] <= bus.imem_rdata;
      pcs_q[wr_q] <= rpc_q;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_START;
      pc_q    <= RESET_PC;
      rpc_q   <= RESET_PC;
      out_q   <= '0;
      disc_q  <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      val_q   <= 1'b0;
      ins_q   <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rpc_q   <= rpc_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      val_q   <= val_d;
      ins_q   <= ins_d;
      ipc_q   <= ipc_d;
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = val_q;
  assign bus.instr       = ins_q;
  assign bus.instr_pc    = ipc_q;

  a_rsp_owed: assert property (
    @(posedge clk) disable iff (!n_rst)
    bus.imem_rvalid |-> (out_q != '0));

  a_out_max: assert property (
    @(posedge clk) disable iff (!n_rst)
    out_q <= CW'(BUF_DEPTH));
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector tables, async reset checks and
// random traffic against a queue-based reference model.
module tb_fetch_unit;
  localparam int D = 2;

  logic clk;
  logic n_rst;

  fetch_unit_if #(.ADDR_W(64)) bus();

  fetch_unit #(
    .ADDR_W(64),
    .RESET_PC(64'h0),
    .BUF_DEPTH(D)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [63:0] pc;
    bit          stale;
  } oreq_t;

  oreq_t       m_out[$];
  logic [63:0] m_buf[$];
  logic [63:0] m_pc;
  bit          m_start;
  logic [63:0] pend[$];

  typedef struct {
    bit          g;
    bit          rv;
    bit          rdy;
    bit          rd;
    logic [63:0] tgt;
    bit          req;
    logic [63:0] addr;
    bit          val;
    logic [63:0] pc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(bit g, bit rv, bit rdy, bit rd,
                             logic [63:0] tgt, bit req,
                             logic [63:0] addr, bit val,
                             logic [63:0] pc);
    vec_t r;
    r.g = g; r.rv = rv; r.rdy = rdy; r.rd = rd; r.tgt = tgt;
    r.req = req; r.addr = addr; r.val = val; r.pc = pc;
    return r;
  endfunction

  function automatic logic [63:0] word(logic [63:0] a);
    return {a[31:0] ^ 32'hA5C3_0F5A, ~a[63:32]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30)
        $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b0;
    n_rst = 1'b0;
    #2;
    chk("rst_req", 64'(bus.imem_req), 64'h0);
    chk("rst_addr", bus.imem_addr, 64'h0);
    chk("rst_valid", 64'(bus.instr_valid), 64'h0);
    chk("rst_instr", bus.instr, 64'h0);
    chk("rst_pc", bus.instr_pc, 64'h0);
    pend.delete();
    m_out.delete();
    m_buf.delete();
    m_pc = 64'h0;
    m_start = 1'b1;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  // entered and left at 1 time unit after a rising edge
  task automatic step(input bit g, input bit rv, input bit rdy,
                      input bit rd, input logic [63:0] tgt,
                      output bit o_req, output logic [63:0] o_addr,
                      output bit o_val, output logic [63:0] o_pc);
    bit    rv_eff;
    bit    pop;
    bit    ereq;
    bit    stale_any;
    oreq_t e;
    rv_eff = rv && (pend.size() > 0);
    bus.imem_gnt    = g;
    bus.instr_ready = rdy;
    bus.redirect    = rd;
    bus.redirect_pc = tgt;
    bus.imem_rvalid = rv_eff;
    bus.imem_rdata  = rv_eff ? word(pend[0]) : 64'h0;
    @(negedge clk);
    stale_any = 1'b0;
    foreach (m_out[i]) if (m_out[i].stale) stale_any = 1'b1;
    pop = (m_buf.size() > 0) && rdy;
    ereq = !m_start && !stale_any && !rd
         && (m_out.size() + m_buf.size() - int'(pop)) < D;
    chk("req", 64'(bus.imem_req), 64'(ereq));
    chk("addr", bus.imem_addr, m_pc);
    chk("valid", 64'(bus.instr_valid), 64'(m_buf.size() > 0));
    if (m_buf.size() > 0) begin
      chk("instr_pc", bus.instr_pc, m_buf[0]);
      chk("instr", bus.instr, word(m_buf[0]));
    end
    o_req  = bus.imem_req;
    o_addr = bus.imem_addr;
    o_val  = bus.instr_valid;
    o_pc   = bus.instr_pc;
    if (rv_eff) void'(pend.pop_front());
    if (bus.imem_req && g) pend.push_back(bus.imem_addr);
    if (pop) void'(m_buf.pop_front());
    if (rv_eff && m_out.size() > 0) begin
      e = m_out.pop_front();
      if (!e.stale && !rd) m_buf.push_back(e.pc);
    end
    if (ereq && g) begin
      m_out.push_back('{pc: m_pc, stale: 1'b0});
      m_pc = m_pc + 64'd8;
    end
    if (rd) begin
      m_buf.delete();
      foreach (m_out[i]) m_out[i].stale = 1'b1;
      m_pc = {tgt[63:3], 3'b000};
    end else begin
      m_start = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_tbl(input string tag);
    bit          o_req;
    bit          o_val;
    logic [63:0] o_addr;
    logic [63:0] o_pc;
    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].g, tv[i].rv, tv[i].rdy, tv[i].rd, tv[i].tgt,
           o_req, o_addr, o_val, o_pc);
      chk($sformatf("%s%0d_req", tag, i), 64'(o_req), 64'(tv[i].req));
      chk($sformatf("%s%0d_addr", tag, i), o_addr, tv[i].addr);
      chk($sformatf("%s%0d_val", tag, i), 64'(o_val), 64'(tv[i].val));
      if (tv[i].val)
        chk($sformatf("%s%0d_pc", tag, i), o_pc, tv[i].pc);
    end
  endtask

  initial begin
    bit          q_req;
    bit          q_val;
    logic [63:0] q_addr;
    logic [63:0] q_pc;
    logic [63:0] tgt;
    n_rst = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b0;
    @(posedge clk);
    #1;

    // streaming with one-cycle memory
    do_reset();
    tv = {};
    tv.push_back(v(1,0,1,0,0, 0,64'h0, 0,64'h0));
    tv.push_back(v(1,0,1,0,0, 1,64'h0, 0,64'h0));
    tv.push_back(v(1,1,1,0,0, 1,64'h8, 0,64'h0));
    tv.push_back(v(1,1,1,0,0, 1,64'h10,1,64'h0));
    tv.push_back(v(1,1,1,0,0, 1,64'h18,1,64'h8));
    tv.push_back(v(1,1,1,0,0, 1,64'h20,1,64'h10));
    run_tbl("A");

    // backpressure, flush, redirect-with-rvalid, grant stall
    do_reset();
    tv = {};
    tv.push_back(v(1,0,0,0,0,        0,64'h0,   0,64'h0));
    tv.push_back(v(1,0,0,0,0,        1,64'h0,   0,64'h0));
    tv.push_back(v(1,1,0,0,0,        1,64'h8,   0,64'h0));
    tv.push_back(v(1,1,0,0,0,        0,64'h10,  1,64'h0));
    tv.push_back(v(1,0,0,0,0,        0,64'h10,  1,64'h0));
    tv.push_back(v(1,0,0,0,0,        0,64'h10,  1,64'h0));
    tv.push_back(v(1,0,1,0,0,        1,64'h10,  1,64'h0));
    tv.push_back(v(1,0,1,0,0,        1,64'h18,  1,64'h8));
    tv.push_back(v(0,0,1,1,64'h1003, 0,64'h20,  0,64'h0));
    tv.push_back(v(1,1,1,0,0,        0,64'h1000,0,64'h0));
    tv.push_back(v(1,1,1,0,0,        0,64'h1000,0,64'h0));
    tv.push_back(v(1,0,1,0,0,        1,64'h1000,0,64'h0));
    tv.push_back(v(1,1,1,0,0,        1,64'h1008,0,64'h0));
    tv.push_back(v(0,1,0,1,64'h2000, 0,64'h1010,1,64'h1000));
    tv.push_back(v(1,0,1,0,0,        1,64'h2000,0,64'h0));
    tv.push_back(v(0,1,1,0,0,        1,64'h2008,0,64'h0));
    tv.push_back(v(0,0,1,0,0,        1,64'h2008,1,64'h2000));
    tv.push_back(v(0,0,1,0,0,        1,64'h2008,0,64'h0));
    tv.push_back(v(0,0,1,0,0,        1,64'h2008,0,64'h0));
    tv.push_back(v(0,0,1,0,0,        1,64'h2008,0,64'h0));
    tv.push_back(v(1,0,1,0,0,        1,64'h2008,0,64'h0));
    tv.push_back(v(1,1,1,0,0,        1,64'h2010,0,64'h0));
    tv.push_back(v(1,1,1,0,0,        1,64'h2018,1,64'h2008));
    run_tbl("B");

    // fill the buffer, then reset mid-stream
    repeat (4) step(1, 1, 0, 0, 0, q_req, q_addr, q_val, q_pc);
    chk("full_valid", 64'(q_val), 64'h1);
    do_reset();
    step(1, 0, 1, 0, 0, q_req, q_addr, q_val, q_pc);
    chk("post_rst_idle", 64'(q_req), 64'h0);
    step(1, 0, 1, 0, 0, q_req, q_addr, q_val, q_pc);
    chk("post_rst_req", 64'(q_req), 64'h1);
    chk("post_rst_addr", q_addr, 64'h0);

    // random traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0)
        tgt = {60'hFFFF_FFFF_FFFF_FFF, 4'($urandom)};
      else
        tgt = {$urandom, $urandom};
      if ($urandom_range(0, 399) == 0) do_reset();
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 24) == 0,
           tgt, q_req, q_addr, q_val, q_pc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
